// File: rtl/cursor_overlay_if.sv
// Video stream bundle between the background generator, the cursor overlay and the VGA output.
// Also carries the cursor position and display controls from the mover.
interface cursor_overlay_if #(
    parameter int RGB_W = 12
);
    logic [10:0]      x_pos;
    logic [9:0]       y_pos;
    logic             show;
    logic             blink_en;
    logic [10:0]      hcount;
    logic [9:0]       vcount;
    logic [RGB_W-1:0] pixel_in;
    logic             hsync_in;
    logic             vsync_in;
    logic             blank_in;
    logic [RGB_W-1:0] pixel_out;
    logic             hsync_out;
    logic             vsync_out;
    logic             blank_out;

    modport master (
        output x_pos, y_pos, show, blink_en,
        output hcount, vcount, pixel_in,
        output hsync_in, vsync_in, blank_in,
        input  pixel_out, hsync_out, vsync_out, blank_out
    );

    modport slave (
        input  x_pos, y_pos, show, blink_en,
        input  hcount, vcount, pixel_in,
        input  hsync_in, vsync_in, blank_in,
        output pixel_out, hsync_out, vsync_out, blank_out
    );
endinterface

// File: rtl/cursor_overlay.sv
// Hollow box cursor composited over the pixel stream, position latched per frame.
// Sync and blank travel through the same PIPE-deep pipeline as the pixel.
module cursor_overlay #(
    parameter int               CUR_W        = 16,
    parameter int               CUR_H        = 16,
    parameter int               PIPE         = 2,
    parameter int               BLINK_FRAMES = 30,
    parameter int               RGB_W        = 12,
    parameter logic [RGB_W-1:0] CUR_COLOR    = RGB_W'(12'hF00)
) (
    input logic             clk,
    input logic             rst,
    cursor_overlay_if.slave bus
);
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [11:0] XW = 12'(CUR_W);
    localparam logic [10:0] YH = 11'(CUR_H);

    logic            vsync_q;
    logic            fall;
    logic [10:0]     x_lat;
    logic [9:0]      y_lat;
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    assign fall = vsync_q & ~bus.vsync_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            x_lat       <= '0;
            y_lat       <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            vsync_q <= bus.vsync_in;
            if (fall) begin
                x_lat <= bus.x_pos;
                y_lat <= bus.y_pos;
                if (frame_cnt == FC_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // One bit wider than the coordinates so a box near the far edge clips.
    logic [11:0] hx, xl, xr;
    logic [10:0] vy, yt, yb;
    logic        in_x, in_y, on_edge, visible, hit_d;

    assign hx = {1'b0, bus.hcount};
    assign xl = {1'b0, x_lat};
    assign xr = xl + XW - 12'd1;
    assign vy = {1'b0, bus.vcount};
    assign yt = {1'b0, y_lat};
    assign yb = yt + YH - 11'd1;

    assign in_x    = (hx >= xl) && (hx <= xr);
    assign in_y    = (vy >= yt) && (vy <= yb);
    assign on_edge = (hx == xl) | (hx == xr) | (vy == yt) | (vy == yb);
    assign visible = bus.show & (~bus.blink_en | blink_phase);
    assign hit_d   = in_x & in_y & on_edge & visible;

    logic [PIPE-1:0]  hit_p;
    logic [PIPE-1:0]  hs_p;
    logic [PIPE-1:0]  vs_p;
    logic [PIPE-1:0]  bl_p;
    logic [RGB_W-1:0] pix_p [PIPE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_p <= '0;
            hs_p  <= '1;
            vs_p  <= '1;
            bl_p  <= '1;
            for (int i = 0; i < PIPE; i++) begin
                pix_p[i] <= '0;
            end
        end else begin
            hit_p[0] <= hit_d;
            hs_p[0]  <= bus.hsync_in;
            vs_p[0]  <= bus.vsync_in;
            bl_p[0]  <= bus.blank_in;
            pix_p[0] <= bus.pixel_in;
            for (int i = 1; i < PIPE; i++) begin
                hit_p[i] <= hit_p[i-1];
                hs_p[i]  <= hs_p[i-1];
                vs_p[i]  <= vs_p[i-1];
                bl_p[i]  <= bl_p[i-1];
                pix_p[i] <= pix_p[i-1];
            end
        end
    end

    // Blank forces black even when the cursor would be drawn there.
    assign bus.pixel_out = bl_p[PIPE-1]  ? '0 :
                           hit_p[PIPE-1] ? CUR_COLOR :
                                           pix_p[PIPE-1];
    assign bus.hsync_out = hs_p[PIPE-1];
    assign bus.vsync_out = vs_p[PIPE-1];
    assign bus.blank_out = bl_p[PIPE-1];
endmodule
